// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, with HDU stall/flush handshake.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            div_req,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_src1,
    input  logic [XLEN-1:0] div_src2,
    input  logic            div_flush,
    output logic            div_stall,
    output logic            div_valid,
    output logic [XLEN-1:0] div_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned magnitude of an operand; the most negative value maps onto itself, which is correct unsigned.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    state_t          state_r, state_nx;
    logic [XLEN-1:0] rem_r, rem_nx;
    logic [XLEN-1:0] quo_r, quo_nx;
    logic [XLEN-1:0] dvs_r, dvs_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic            is_rem_r, is_rem_nx;
    logic            neg_q_r, neg_q_nx;
    logic            neg_r_r, neg_r_nx;
    logic [XLEN-1:0] result_r, result_nx;

    logic            sgn_s;
    logic [XLEN-1:0] abs1_s, abs2_s;
    logic            dvs_zero_s, ovf_s;
    logic [XLEN:0]   rem_sh_s, diff_s;
    logic            div_stall_s;

    // Operand decode and the XLEN+1-bit trial subtraction; diff_s[XLEN] set means restore.
    always_comb begin
        sgn_s      = ~div_op[0];
        abs1_s     = mag(div_src1, sgn_s);
        abs2_s     = mag(div_src2, sgn_s);
        dvs_zero_s = (div_src2 == ZERO);
        ovf_s      = sgn_s && (div_src1 == MIN_NEG) && (div_src2 == ALL_ONES);
        rem_sh_s   = {rem_r, quo_r[XLEN-1]};
        diff_s     = rem_sh_s - {1'b0, dvs_r};
    end

    // Next-state, datapath update and stall request.
    always_comb begin
        state_nx    = state_r;
        rem_nx      = rem_r;
        quo_nx      = quo_r;
        dvs_nx      = dvs_r;
        cnt_nx      = cnt_r;
        is_rem_nx   = is_rem_r;
        neg_q_nx    = neg_q_r;
        neg_r_nx    = neg_r_r;
        result_nx   = result_r;
        div_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                div_stall_s = div_req & ~div_flush;
                if (div_req && !div_flush) begin
                    is_rem_nx = div_op[1];
                    neg_q_nx  = sgn_s & (div_src1[XLEN-1] ^ div_src2[XLEN-1]);
                    neg_r_nx  = sgn_s & div_src1[XLEN-1];
                    quo_nx    = abs1_s;
                    dvs_nx    = abs2_s;
                    rem_nx    = ZERO;
                    cnt_nx    = {CNT_W{1'b0}};
                    if (dvs_zero_s) begin
                        state_nx  = ST_DONE;
                        result_nx = div_op[1] ? div_src1 : ALL_ONES;
                    end else if (ovf_s) begin
                        state_nx  = ST_DONE;
                        result_nx = div_op[1] ? ZERO : MIN_NEG;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs1_s < abs2_s) begin
                        state_nx  = ST_DONE;
                        result_nx = div_op[1] ? div_src1 : ZERO;
                    end
`endif
                    else begin
                        state_nx = ST_BUSY;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_BUSY: begin
                div_stall_s = ~div_flush;
                if (div_flush) begin
                    state_nx = ST_IDLE;
                end else begin
                    rem_nx = diff_s[XLEN] ? rem_sh_s[XLEN-1:0] : diff_s[XLEN-1:0];
                    quo_nx = {quo_r[XLEN-2:0], ~diff_s[XLEN]};
                    cnt_nx = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_nx  = ST_DONE;
                        result_nx = is_rem_r ? sign_fix(rem_nx, neg_r_r) : sign_fix(quo_nx, neg_q_r);
                    end else begin
                        state_nx = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r  <= ST_IDLE;
            rem_r    <= {XLEN{1'b0}};
            quo_r    <= {XLEN{1'b0}};
            dvs_r    <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            state_r  <= state_nx;
            rem_r    <= rem_nx;
            quo_r    <= quo_nx;
            dvs_r    <= dvs_nx;
            cnt_r    <= cnt_nx;
            is_rem_r <= is_rem_nx;
            neg_q_r  <= neg_q_nx;
            neg_r_r  <= neg_r_nx;
            result_r <= result_nx;
        end
    end

    assign div_stall  = div_stall_s;
    assign div_valid  = (state_r == ST_DONE);
    assign div_result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit: result values, stall/valid timing, flush and reset corners.
module tb_div_unit;

    logic        clk;
    logic        rst_b;
    logic        div_req;
    logic [1:0]  div_op;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_flush;
    logic        div_stall;
    logic        div_valid;
    logic [31:0] div_result;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;
    localparam int GEN_LAT = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .div_req    (div_req),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_flush  (div_flush),
        .div_stall  (div_stall),
        .div_valid  (div_valid),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Entered at posedge+1 of the request cycle; returns at posedge+1 of the cycle after div_valid.
    task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic        patt_ok;
        logic [31:0] res;
        div_req  = 1'b1;
        div_op   = op;
        div_src1 = a;
        div_src2 = b;
        lat      = -1;
        patt_ok  = 1'b1;
        res      = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_valid) begin
                lat = k;
                res = div_result;
                if (div_stall) patt_ok = 1'b0;
                break;
            end
            if (div_stall !== (k < exp_lat)) patt_ok = 1'b0;
            @(posedge clk); #1;
        end
        check({nm, "_lat"}, lat, exp_lat);
        check({nm, "_stall"}, {31'd0, patt_ok}, 32'd1);
        check({nm, "_res"}, res, exp_res);
        @(posedge clk); #1;
        div_req = 1'b0;
    endtask

    initial begin
        int vcnt;
        int nvalid;
        logic patt_ok;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         GEN_LAT};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          GEN_LAT};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  GEN_LAT};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  GEN_LAT};
        vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          GEN_LAT};
        vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  GEN_LAT};
        vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[10] = '{OP_DIVU, 32'd20,         32'd4,          32'd5,          GEN_LAT};
        vecs[11] = '{OP_REMU, 32'd20,         32'd6,          32'd2,          GEN_LAT};
        vecs[12] = '{OP_DIVU, 32'd3,          32'd10,         32'd0,          EO_LAT};
        vecs[13] = '{OP_REMU, 32'd3,          32'd10,         32'd3,          EO_LAT};
        vecs[14] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  GEN_LAT};
        vecs[15] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  GEN_LAT};
        vcnt = 16;

        rst_b     = 1'b0;
        div_req   = 1'b0;
        div_op    = 2'd0;
        div_src1  = 32'd0;
        div_src2  = 32'd0;
        div_flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, div_stall}, 32'd0);
        check("rst_valid", {31'd0, div_valid}, 32'd0);
        check("rst_result", div_result, 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;

        // Table entries run back-to-back: each request lands in the IDLE cycle right after DONE.
        for (int i = 0; i < vcnt; i++) begin
            do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        @(negedge clk);
        check("hold_result", div_result, vecs[vcnt-1].res);
        check("hold_valid", {31'd0, div_valid}, 32'd0);
        @(posedge clk); #1;

        // Flush in BUSY at cycle t+10.
        div_req  = 1'b1;
        div_op   = OP_DIVU;
        div_src1 = 32'd100;
        div_src2 = 32'd7;
        patt_ok  = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) div_flush = 1'b1;
            @(negedge clk);
            if (div_stall !== (k < 10)) patt_ok = 1'b0;
            if (div_valid) patt_ok = 1'b0;
            @(posedge clk); #1;
        end
        div_req   = 1'b0;
        div_flush = 1'b0;
        nvalid    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_valid) nvalid++;
            if (div_stall) patt_ok = 1'b0;
        end
        check("flush_stall", {31'd0, patt_ok}, 32'd1);
        check("flush_novalid", nvalid, 32'd0);
        @(posedge clk); #1;
        do_op("after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, GEN_LAT);

        // Reset pulsed mid-BUSY.
        div_req  = 1'b1;
        div_op   = OP_DIVU;
        div_src1 = 32'd100;
        div_src2 = 32'd7;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_b   = 1'b0;
        div_req = 1'b0;
        #2;
        check("midrst_stall", {31'd0, div_stall}, 32'd0);
        check("midrst_valid", {31'd0, div_valid}, 32'd0);
        check("midrst_result", div_result, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        do_op("after_rst", OP_REMU, 32'd20, 32'd6, 32'd2, GEN_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU ops; sits in EX beside the ALU.
- Raises a stall request toward the hazard detection unit while an iteration is in progress, and accepts a flush from it.
- It is the requester side of the stall/flush interface: the HDU consumes `div_stall` and drives `div_flush`.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.

Ports:
- clk  in  1  core clock
- rst_b  in  1  asynchronous active-low reset
- div_req  in  1  EX holds a valid divide-class instruction; held high while stalled
- div_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- div_src1  in  XLEN  dividend (rs1); stable while div_req is high
- div_src2  in  XLEN  divisor (rs2); stable while div_req is high
- div_flush  in  1  kill the in-flight divide (branch/trap flush of EX)
- div_stall  out  1  to HDU: hold IF/ID/EX, bubble MEM
- div_valid  out  1  result valid this cycle (single-cycle pulse)
- div_result  out  XLEN  quotient or remainder per div_op

Behaviour:
- Reset: all state is asynchronously cleared; state=IDLE; div_stall=0, div_valid=0, div_result=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_stall = div_req & ~div_flush (combinational).
  - On div_req & ~div_flush, latch op, sign flags, |src1|, |src2|.
  - Special case divisor==0: DONE with quotient=all-ones, remainder=src1.
  - Special case signed overflow (DIV/REM, src1=0x8000_0000, src2=all-ones): DONE with quotient=0x8000_0000, remainder=0.
  - Otherwise go to BUSY with count=0, partial remainder=0.
- BUSY:
  - One restoring step per cycle: shift {rem,quo} left 1; if rem ≥ divisor, subtract and set the quotient LSB.
  - Subtraction is XLEN+1 bits wide; the carry-out selects the result.
  - count increments; after XLEN steps (count==XLEN-1) go to DONE.
  - div_stall=1 throughout.
- DONE:
  - div_valid=1, div_stall=0; pipeline advances this cycle. Next state is IDLE.
  - Final sign fix: quotient negated if signed and signs differ; remainder takes the dividend's sign.
  - div_result is the registered value; it holds after DONE until the next DONE.
- Latency:
  - General case: req at cycle t gives stall t..t+XLEN and div_valid at t+XLEN+1.
  - Special case: stall at t only, div_valid at t+1.
- Back-to-back: div_req high in the IDLE cycle following DONE starts a new operation; no lost or duplicate results.
- Flush in BUSY or IDLE: state becomes IDLE next cycle, no div_valid, div_stall deasserts that cycle.
- Flush in DONE: div_valid still asserts (HDU discards it); state returns to IDLE.
- div_req dropping in BUSY without a flush is illegal; the block completes anyway and asserts div_valid.
- Reset mid-BUSY: immediate IDLE; the result is discarded.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |src1| < |src2| (unsigned magnitudes, divisor≠0), go straight to DONE with quotient=0 and remainder=src1. Stall lasts 1 cycle; div_valid at t+1.
- Undefined: these cases take the full XLEN+1 stall cycles, with an identical result value.

Test Plan:
- DIVU 100/7 → stall 33 cycles, div_valid at t+33, result 14; REMU same operands → 2.
- DIV -7/2 → 0xFFFF_FFFD (-3); REM -7/2 → 0xFFFF_FFFF (-1); REM 7/-2 → 1.
- DIV 5/0 → 0xFFFF_FFFF at t+1; REMU 5/0 → 5; DIV 0x8000_0000/-1 → 0x8000_0000 at t+1, REM → 0.
- DIVU 100/7 with div_flush asserted at t+10 → stall drops at t+10, no div_valid ever. Follow with DIVU 9/3 → 3 at normal latency.
- Back-to-back DIVU 20/4 then REMU 20/6 → two single div_valid pulses with results 5 then 2, separated by one IDLE cycle.
- DIVU 3/10: with DIV_EARLY_OUT_EN → result 0 at t+1; without it → result 0 at t+33. rst_b pulsed mid-BUSY → all outputs 0, state IDLE.
